// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu -- memory stage of the 5-stage RV32I pipeline.
//
// Takes the EX/MEM pipeline register outputs, performs loads and stores over a
// registered req/ack data-memory port, and holds the MEM/WB pipeline register.
//
// Ports:
//   clk, rstN              clock (rising edge) and asynchronous active-low reset
//   *_MEM_In               EX/MEM register fields (control, func3, address, store data, rd)
//   stall_MEM_Out          freeze PC, IF/ID, ID/EX, EX/MEM while a bus access is in flight
//   dmem_req/we/addr/be/wdata  registered bus request (word address, byte enables, lane-steered data)
//   dmem_rdata, dmem_ack   read data, valid with the one-cycle ack pulse
//   *_WB_Out               MEM/WB register outputs
//
// Optional build macro: MISALIGN_TRAP_EN
//   defined   : misaligned LH/LHU/SH/LW/SW skip the bus and raise misaligned_WB_Out
//   undefined : misaligned_WB_Out is 0, misaligned addresses fall onto the natural lanes
module mem_stage_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              memWrite_MEM_In,
  input  logic              memRead_MEM_In,
  input  logic              regWrite_MEM_In,
  input  logic              memToRegWrite_MEM_In,
  input  logic [2:0]        func3_MEM_In,
  input  logic [31:0]       aluOut_MEM_In,
  input  logic [31:0]       aluSrc2_MEM_In,
  input  logic [4:0]        rd_MEM_In,
  output logic              stall_MEM_Out,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              regWrite_WB_Out,
  output logic              memToRegWrite_WB_Out,
  output logic [31:0]       loadData_WB_Out,
  output logic [31:0]       aluOut_WB_Out,
  output logic [4:0]        rd_WB_Out,
  output logic              misaligned_WB_Out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [1:0]  lane;
  logic        access;
  logic        misaligned;
  logic        bus_access;
  logic [31:0] ld_data_p1;

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000:  return 4'b0001 << a;
      3'b001:  return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return {4{d[7:0]}};
      3'b001:  return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] rd);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = rd[{a, 3'b000} +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  return 32'(b);
      3'b001:  return 32'(h);
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return rd;
    endcase
  endfunction

`ifdef MISALIGN_TRAP_EN
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b001, 3'b101: return a[0];
      3'b010:         return |a;
      default:        return 1'b0;
    endcase
  endfunction

  assign misaligned = access & is_misaligned(func3_MEM_In, lane);
`else
  assign misaligned = 1'b0;
`endif

  assign lane       = aluOut_MEM_In[1:0];
  assign access     = memRead_MEM_In | memWrite_MEM_In;
  assign bus_access = access & ~misaligned;

  // Stall is gated by reset so the upstream pipeline is not frozen while held in reset.
  assign stall_MEM_Out = rstN & (((state == IDLE) & bus_access) | (state == BUSY));

  // Bus access FSM: IDLE issues, BUSY waits for ack, DONE lets EX/MEM advance.
  // EX/MEM is frozen while stalled, so the stage inputs are still valid on ack.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= 4'd0;
      dmem_wdata <= 32'd0;
      ld_data_p1 <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus_access) begin
            dmem_req   <= 1'b1;
            // A simultaneous read and write request is handled as a read.
            dmem_we    <= memWrite_MEM_In & ~memRead_MEM_In;
            dmem_addr  <= {aluOut_MEM_In[ADDR_W-1:2], 2'b00};
            dmem_be    <= memRead_MEM_In ? 4'b1111 : store_be(func3_MEM_In, lane);
            dmem_wdata <= store_wdata(func3_MEM_In, aluSrc2_MEM_In);
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (!dmem_we) ld_data_p1 <= format_load(func3_MEM_In, lane, dmem_rdata);
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // MEM/WB pipeline register: bubble while stalled, otherwise take the stage result.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      regWrite_WB_Out      <= 1'b0;
      memToRegWrite_WB_Out <= 1'b0;
      loadData_WB_Out      <= 32'd0;
      aluOut_WB_Out        <= 32'd0;
      rd_WB_Out            <= 5'd0;
      misaligned_WB_Out    <= 1'b0;
    end else if (stall_MEM_Out) begin
      regWrite_WB_Out      <= 1'b0;
      memToRegWrite_WB_Out <= 1'b0;
      misaligned_WB_Out    <= 1'b0;
    end else begin
      regWrite_WB_Out      <= regWrite_MEM_In & ~misaligned;
      memToRegWrite_WB_Out <= memToRegWrite_MEM_In;
      loadData_WB_Out      <= ((state == DONE) && !dmem_we) ? ld_data_p1 : 32'd0;
      aluOut_WB_Out        <= aluOut_MEM_In;
      rd_WB_Out            <= rd_MEM_In;
      misaligned_WB_Out    <= misaligned;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rstN;
  logic        memWrite_MEM_In, memRead_MEM_In, regWrite_MEM_In, memToRegWrite_MEM_In;
  logic [2:0]  func3_MEM_In;
  logic [31:0] aluOut_MEM_In, aluSrc2_MEM_In;
  logic [4:0]  rd_MEM_In;
  logic        stall_MEM_Out;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        regWrite_WB_Out, memToRegWrite_WB_Out;
  logic [31:0] loadData_WB_Out, aluOut_WB_Out;
  logic [4:0]  rd_WB_Out;
  logic        misaligned_WB_Out;

  int checks = 0;
  int errors = 0;

  mem_stage_lsu #(.ADDR_W(32)) dut (
    .clk(clk), .rstN(rstN),
    .memWrite_MEM_In(memWrite_MEM_In), .memRead_MEM_In(memRead_MEM_In),
    .regWrite_MEM_In(regWrite_MEM_In), .memToRegWrite_MEM_In(memToRegWrite_MEM_In),
    .func3_MEM_In(func3_MEM_In), .aluOut_MEM_In(aluOut_MEM_In),
    .aluSrc2_MEM_In(aluSrc2_MEM_In), .rd_MEM_In(rd_MEM_In),
    .stall_MEM_Out(stall_MEM_Out),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .regWrite_WB_Out(regWrite_WB_Out), .memToRegWrite_WB_Out(memToRegWrite_WB_Out),
    .loadData_WB_Out(loadData_WB_Out), .aluOut_WB_Out(aluOut_WB_Out),
    .rd_WB_Out(rd_WB_Out), .misaligned_WB_Out(misaligned_WB_Out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic mw, input logic mr, input logic rw, input logic m2r,
                        input logic [2:0] f3, input logic [31:0] alu,
                        input logic [31:0] src2, input logic [4:0] rd);
    memWrite_MEM_In      = mw;
    memRead_MEM_In       = mr;
    regWrite_MEM_In      = rw;
    memToRegWrite_MEM_In = m2r;
    func3_MEM_In         = f3;
    aluOut_MEM_In        = alu;
    aluSrc2_MEM_In       = src2;
    rd_MEM_In            = rd;
  endtask

  task automatic nop();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
  endtask

  // Acts as the memory: acks dly cycles after req is seen. Returns in the first
  // cycle with stall low (DONE for a memory op), reporting stall cycles, req
  // rising edges and the bus fields captured when req first rose.
  task automatic run_mem(input int dly, output int stalls, output int reqs,
                         output logic [31:0] a, output logic [3:0] be,
                         output logic [31:0] wd, output logic we);
    int  hi;
    logic prev;
    logic done;
    stalls = 0; reqs = 0; hi = 0; prev = 1'b0; done = 1'b0;
    a = 32'd0; be = 4'd0; wd = 32'd0; we = 1'b0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (!stall_MEM_Out) begin
        done = 1'b1;
        break;
      end
      stalls++;
      if (dmem_req && !prev) begin
        reqs++;
        a = dmem_addr; be = dmem_be; wd = dmem_wdata; we = dmem_we;
      end
      prev = dmem_req;
      if (dmem_req) begin
        if (hi == dly) dmem_ack = 1'b1;
        hi++;
      end
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL run_mem_timeout observed stall held expected completion");
    end
  endtask

  int          st, rq;
  logic [31:0] ba, bwd;
  logic [3:0]  bbe;
  logic        bwe;

  initial begin
    rstN = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
    nop();
    tick(); tick();

    // Reset state
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_stall", 32'(stall_MEM_Out), 32'd0);
    check("rst_wb_rw", 32'(regWrite_WB_Out), 32'd0);
    check("rst_wb_alu", aluOut_WB_Out, 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    rstN = 1'b1;
    tick();

    // ADD, non-memory: one cycle, no stall
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0000_1234, 32'd0, 5'd5);
    #1;
    check("add_stall", 32'(stall_MEM_Out), 32'd0);
    tick();
    check("add_wb_rw", 32'(regWrite_WB_Out), 32'd1);
    check("add_wb_alu", aluOut_WB_Out, 32'h0000_1234);
    check("add_wb_rd", 32'(rd_WB_Out), 32'd5);
    check("add_wb_ld", loadData_WB_Out, 32'd0);
    check("add_req", 32'(dmem_req), 32'd0);
    nop();

    // LB 0x103, ack two cycles after req
    dmem_rdata = 32'h80FF_FF7F;
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 32'h0000_0103, 32'd0, 5'd7);
    run_mem(2, st, rq, ba, bbe, bwd, bwe);
    check("lb_stalls", 32'(st), 32'd4);
    check("lb_reqs", 32'(rq), 32'd1);
    check("lb_addr", ba, 32'h0000_0100);
    check("lb_be", 32'(bbe), 32'hF);
    check("lb_we", 32'(bwe), 32'd0);
    check("lb_done_req", 32'(dmem_req), 32'd0);
    check("lb_done_wb_rw", 32'(regWrite_WB_Out), 32'd0);
    tick();
    check("lb_wb_ld", loadData_WB_Out, 32'hFFFF_FF80);
    check("lb_wb_rw", 32'(regWrite_WB_Out), 32'd1);
    check("lb_wb_m2r", 32'(memToRegWrite_WB_Out), 32'd1);
    check("lb_wb_rd", 32'(rd_WB_Out), 32'd7);

    // LBU same address
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 3'b100, 32'h0000_0103, 32'd0, 5'd8);
    run_mem(2, st, rq, ba, bbe, bwd, bwe);
    check("lbu_stalls", 32'(st), 32'd4);
    tick();
    check("lbu_wb_ld", loadData_WB_Out, 32'h0000_0080);

    // LH / LHU upper halfword, same-cycle ack
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 3'b001, 32'h0000_0102, 32'd0, 5'd9);
    run_mem(0, st, rq, ba, bbe, bwd, bwe);
    check("lh_stalls", 32'(st), 32'd2);
    tick();
    check("lh_wb_ld", loadData_WB_Out, 32'hFFFF_80FF);
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 3'b101, 32'h0000_0102, 32'd0, 5'd9);
    run_mem(0, st, rq, ba, bbe, bwd, bwe);
    tick();
    check("lhu_wb_ld", loadData_WB_Out, 32'h0000_80FF);
    nop();

    // SH 0x202, ack same cycle as req
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 5'd0);
    run_mem(0, st, rq, ba, bbe, bwd, bwe);
    check("sh_stalls", 32'(st), 32'd2);
    check("sh_we", 32'(bwe), 32'd1);
    check("sh_be", 32'(bbe), 32'hC);
    check("sh_wdata", bwd, 32'hBEEF_BEEF);
    check("sh_addr", ba, 32'h0000_0200);
    tick();
    check("sh_wb_rw", 32'(regWrite_WB_Out), 32'd0);
    check("sh_wb_ld", loadData_WB_Out, 32'd0);

    // SB 0x301
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0000_0301, 32'h1234_56A5, 5'd0);
    run_mem(0, st, rq, ba, bbe, bwd, bwe);
    check("sb_be", 32'(bbe), 32'h2);
    check("sb_wdata", bwd, 32'hA5A5_A5A5);
    tick();
    nop();

    // Back-to-back LW 0x10 then SW 0x14, ack after one cycle each
    dmem_rdata = 32'h1122_3344;
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 32'h0000_0010, 32'd0, 5'd3);
    run_mem(1, st, rq, ba, bbe, bwd, bwe);
    check("lw_stalls", 32'(st), 32'd3);
    check("lw_reqs", 32'(rq), 32'd1);
    check("lw_done_req", 32'(dmem_req), 32'd0);
    tick();
    check("lw_wb_ld", loadData_WB_Out, 32'h1122_3344);
    check("lw_wb_rw", 32'(regWrite_WB_Out), 32'd1);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 32'h0000_0014, 32'hCAFE_F00D, 5'd0);
    run_mem(1, st, rq, ba, bbe, bwd, bwe);
    check("sw_stalls", 32'(st), 32'd3);
    check("sw_reqs", 32'(rq), 32'd1);
    check("sw_addr", ba, 32'h0000_0014);
    check("sw_be", 32'(bbe), 32'hF);
    check("sw_wdata", bwd, 32'hCAFE_F00D);
    check("sw_done_req", 32'(dmem_req), 32'd0);
    check("sw_done_wb_rw", 32'(regWrite_WB_Out), 32'd0);
    tick();
    check("sw_wb_rw", 32'(regWrite_WB_Out), 32'd0);
    nop();

    // Ack while idle is ignored
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    check("idle_ack_req", 32'(dmem_req), 32'd0);
    check("idle_ack_stall", 32'(stall_MEM_Out), 32'd0);

    // Misaligned LW 0x102
    dmem_rdata = 32'hA1B2_C3D4;
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 32'h0000_0102, 32'd0, 5'd4);
`ifdef MISALIGN_TRAP_EN
    #1;
    check("mis_stall", 32'(stall_MEM_Out), 32'd0);
    tick();
    check("mis_req", 32'(dmem_req), 32'd0);
    check("mis_flag", 32'(misaligned_WB_Out), 32'd1);
    check("mis_wb_rw", 32'(regWrite_WB_Out), 32'd0);
`else
    run_mem(0, st, rq, ba, bbe, bwd, bwe);
    check("mis_addr", ba, 32'h0000_0100);
    tick();
    check("mis_wb_ld", loadData_WB_Out, 32'hA1B2_C3D4);
    check("mis_flag", 32'(misaligned_WB_Out), 32'd0);
`endif
    nop();
    tick();

    // Reset in the middle of BUSY
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 32'h0000_0040, 32'd0, 5'd6);
    tick();
    tick();
    check("rb_req_busy", 32'(dmem_req), 32'd1);
    rstN = 1'b0;
    #1;
    check("rb_req", 32'(dmem_req), 32'd0);
    check("rb_stall", 32'(stall_MEM_Out), 32'd0);
    check("rb_wb_rw", 32'(regWrite_WB_Out), 32'd0);
    check("rb_wb_ld", loadData_WB_Out, 32'd0);
    check("rb_wb_rd", 32'(rd_WB_Out), 32'd0);
    nop();
    tick();
    rstN = 1'b1;
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    tick();
    check("rb_post_req", 32'(dmem_req), 32'd0);
    check("rb_post_wb_rw", 32'(regWrite_WB_Out), 32'd0);
    check("rb_post_wb_ld", loadData_WB_Out, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Memory stage of the 5-stage RISC-V pipeline, consuming the EX/MEM pipeline register outputs and feeding the write-back stage.
- Performs RV32I loads and stores over a req/ack data-memory port, with byte-lane steering and load sign/zero extension.
- Stalls upstream stages while a bus access is outstanding.
- Contains the MEM/WB pipeline register, so write-back inputs are registered outputs of this block.

Parameters:
ADDR_W, 32, data-memory byte-address width (aluOut_MEM_In[ADDR_W-1:0] used; dmem_addr is word-aligned)

Ports:
clk  in  1  clock, all state on rising edge
rstN  in  1  asynchronous active-low reset
memWrite_MEM_In  in  1  store request from EX/MEM
memRead_MEM_In  in  1  load request from EX/MEM
regWrite_MEM_In  in  1  register write enable from EX/MEM
memToRegWrite_MEM_In  in  1  select load data for write-back
func3_MEM_In  in  3  access size/sign (RV32I encoding)
aluOut_MEM_In  in  32  effective address / ALU result
aluSrc2_MEM_In  in  32  store data (rs2)
rd_MEM_In  in  5  destination register
stall_MEM_Out  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
dmem_req  out  1  bus request, registered
dmem_we  out  1  1=write, valid with req
dmem_addr  out  ADDR_W  word address, bits[1:0]=0
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-steered store data
dmem_rdata  in  32  read data, valid with ack
dmem_ack  in  1  one-cycle completion pulse
regWrite_WB_Out  out  1  registered
memToRegWrite_WB_Out  out  1  registered
loadData_WB_Out  out  32  formatted load result, registered
aluOut_WB_Out  out  32  registered ALU result
rd_WB_Out  out  5  registered
misaligned_WB_Out  out  1  registered misalignment flag (see optional feature)

Behaviour:
- Reset (rstN=0, async): state=IDLE; dmem_req, dmem_we=0; dmem_addr, dmem_be, dmem_wdata=0; all *_WB_Out=0; rdata capture register=0.
- access = memRead_MEM_In | memWrite_MEM_In. If both are set, the access is treated as a read.
- FSM states:
  - IDLE: if access, latch addr/be/wdata/we into bus registers, set dmem_req=1, go to BUSY.
  - BUSY: hold req and all bus outputs stable until dmem_ack. On ack: req<=0; capture formatted dmem_rdata (reads only); go to DONE.
  - DONE: no bus activity; go to IDLE.
- stall_MEM_Out (combinational) = (IDLE & access) | BUSY. It is low in DONE, so EX/MEM advances at the end of DONE.
- MEM/WB register, loaded every cycle:
  - stall=1: load a bubble (regWrite=0, memToRegWrite=0, misaligned=0; other fields don't-care, hold).
  - stall=0: load the stage inputs, plus captured load data (DONE) or 0 (non-memory instruction).
- Latency:
  - Non-memory instruction: 1 cycle, no stall.
  - Memory instruction: min 3 cycles (IDLE, BUSY with same-cycle ack, DONE); +1 per ack wait cycle.
- Stores, by func3 (lanes from addr[1:0]):
  - 000 SB: be=0001<<a[1:0]; wdata = byte replicated x4.
  - 001 SH: be=0011<<{a[1],0}; wdata = halfword replicated x2.
  - 010 SW: be=1111.
  - Other codes: SW.
- Loads (be=1111 on bus; extract from the lane selected by a[1:0]):
  - 000 LB: sign-extend.
  - 001 LH: sign-extend, halfword at a[1].
  - 010 LW: word.
  - 100 LBU, 101 LHU: zero-extend.
  - Other codes: LW.
- Without MISALIGN_TRAP_EN, a misaligned access uses the lane rule above: LH/SH ignore a[0]; LW/SW ignore a[1:0].
- An ack arriving in IDLE or DONE is ignored.
- Reset during BUSY aborts the access: req drops immediately and no write-back occurs.

Optional Feature:
MISALIGN_TRAP_EN:
- Defined:
  - LH/LHU/SH with a[0]=1, or LW/SW with a[1:0]!=0, is misaligned.
  - No bus access and no stall; passes in 1 cycle.
  - MEM/WB loads misaligned_WB_Out=1 with regWrite_WB_Out=0.
- Undefined: misaligned_WB_Out is tied 0; lane rule applies.

Test Plan:
- Reset mid-BUSY (LW issued, no ack, rstN=0) -> dmem_req=0 immediately, stall=0, all WB outputs 0; after release, no spurious write-back.
- ADD result 0x0000_1234 rd=5 regWrite=1 -> next cycle regWrite_WB_Out=1, aluOut_WB_Out=0x1234, rd_WB_Out=5, stall never high.
- LB addr=0x103, dmem_rdata=0x80FF_FF7F, ack 2 cycles after req -> dmem_addr=0x100, stall high 4 cycles, loadData_WB_Out=0xFFFF_FF80; LBU same -> 0x0000_0080.
- SH addr=0x202 data=0xDEAD_BEEF, ack same cycle as req -> dmem_we=1, dmem_be=1100, dmem_wdata=0xBEEF_BEEF, regWrite_WB_Out=0 after DONE.
- Back-to-back LW 0x10 then SW 0x14, each ack after 1 cycle -> exactly one req per instruction, req low in DONE, no double write-back.
- LW addr=0x102 with MISALIGN_TRAP_EN defined -> no dmem_req, no stall, misaligned_WB_Out=1, regWrite_WB_Out=0.
